run_sequence_detector: RTL and testbench

//  Streaming detector for ordered symbol runs 1^a 2^b ... N^z (each run >= MIN_RUN long).

---
 rtl/run_sequence_detector.sv | 98 +++++++++
 tb/tb_run_sequence_detector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequence_detector.sv
// Streaming detector for ordered symbol runs 1^a 2^b ... N^z, each run at least MIN_RUN long.
// Optional macro RUN_MAX_CHECK_EN: runs longer than MAX_RUN abort the pattern (stage 1 restarts instead).
module run_sequence_detector #(
    parameter int SYM_W      = 2,
    parameter int NUM_STAGES = 3,
    parameter int RUN_W      = 4,
    parameter int MIN_RUN    = 1,
    parameter int CNT_W      = 8,
    parameter int MAX_RUN    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] sym,
    output logic             ans,
    output logic [SYM_W-1:0] stage,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [SYM_W-1:0] ST_IDLE  = '0;
    localparam logic [SYM_W-1:0] ST_FIRST = SYM_W'(1);
    localparam logic [SYM_W-1:0] ST_LAST  = SYM_W'(NUM_STAGES);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MIN  = RUN_W'(MIN_RUN);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_SAT  = '1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

`ifdef RUN_MAX_CHECK_EN
    localparam bit MAX_CHECK = 1'b1;
`else
    localparam bit MAX_CHECK = 1'b0;
`endif

    logic [SYM_W-1:0] stage_q, stage_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             ans_q, ans_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             same_run, adv_ok;

    // stage_q < ST_LAST keeps stage_q + 1 from wrapping inside SYM_W bits
    assign same_run = (sym == stage_q) && (stage_q != ST_IDLE);
    assign adv_ok   = (stage_q != ST_IDLE) && (stage_q < ST_LAST) &&
                      (sym == stage_q + ST_FIRST) && (run_q >= RUN_MIN);

    always_comb begin
        stage_d = stage_q;
        run_d   = run_q;
        if (in_valid) begin
            if (same_run) begin
                if (MAX_CHECK && (run_q >= RUN_MAX)) begin
                    // an over-long run of 1s is simply a fresh start of stage 1
                    stage_d = (stage_q == ST_FIRST) ? ST_FIRST : ST_IDLE;
                    run_d   = (stage_q == ST_FIRST) ? RUN_ONE : '0;
                end else if (run_q != RUN_SAT) begin
                    run_d = run_q + RUN_ONE;
                end
            end else if (adv_ok) begin
                stage_d = stage_q + ST_FIRST;
                run_d   = RUN_ONE;
            end else if (sym == ST_FIRST) begin
                stage_d = ST_FIRST;
                run_d   = RUN_ONE;
            end else begin
                stage_d = ST_IDLE;
                run_d   = '0;
            end
        end
    end

    assign ans_d = (stage_d == ST_LAST) && (run_d >= RUN_MIN);
    assign cnt_d = (ans_d && !ans_q && (cnt_q != CNT_SAT)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= ST_IDLE;
            run_q   <= '0;
            ans_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (clr) begin
            stage_q <= ST_IDLE;
            run_q   <= '0;
            ans_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            run_q   <= run_d;
            ans_q   <= ans_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ans       = ans_q;
    assign stage     = stage_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_run_sequence_detector.sv
// Bench for run_sequence_detector: three configurations driven in parallel, checked
// against a run-length history model plus fixed vector tables and hand sequences.
module tb_run_sequence_detector;
    localparam int NS = 3;
    localparam int MINR [3] = '{1, 2, 1};
    localparam int MAXR [3] = '{15, 15, 2};
    localparam int CMAX [3] = '{255, 255, 3};
`ifdef RUN_MAX_CHECK_EN
    localparam bit MAXCHK = 1'b1;
`else
    localparam bit MAXCHK = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0;
    logic [1:0] sym = 2'd0;
    logic       ans0, ans1, ans2;
    logic [1:0] st0, st1, st2;
    logic [7:0] mc0, mc1;
    logic [1:0] mc2;

    always #5 clk = ~clk;

    run_sequence_detector u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .sym(sym),
        .ans(ans0), .stage(st0), .match_cnt(mc0));
    run_sequence_detector #(.MIN_RUN(2)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .sym(sym),
        .ans(ans1), .stage(st1), .match_cnt(mc1));
    run_sequence_detector #(.MAX_RUN(2), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .sym(sym),
        .ans(ans2), .stage(st2), .match_cnt(mc2));

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Model: most recent runs of accepted symbols (index 0 = current run).
    int hs [3][8];
    int hl [3][8];
    int nr [3];
    int mcnt [3];
    int mst [3];
    bit mans [3];

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            nr[c] = 0; mcnt[c] = 0; mans[c] = 1'b0; mst[c] = 0;
        end
    endtask

    task automatic model_push(input int s);
        for (int c = 0; c < 3; c++) begin
            if (nr[c] > 0 && hs[c][0] == s) hl[c][0]++;
            else begin
                for (int i = 7; i > 0; i--) begin
                    hs[c][i] = hs[c][i-1]; hl[c][i] = hl[c][i-1];
                end
                hs[c][0] = s; hl[c][0] = 1;
                if (nr[c] < 8) nr[c]++;
            end
        end
    endtask

    // Length of a run of 1s that counts: with the max check, over-long runs restart.
    function automatic int ones_len(input int len, input int mx);
        return MAXCHK ? ((len - 1) % mx) + 1 : len;
    endfunction

    // Stage v is live iff the trailing runs read 1,2,..,v with every earlier run qualified.
    function automatic void model_eval(input int c, output int st, output int r);
        int v, len;
        st = 0; r = 0;
        if (nr[c] == 0) return;
        v = hs[c][0]; len = hl[c][0];
        if (v < 1 || v > NS) return;
        if (v == 1) begin st = 1; r = ones_len(len, MAXR[c]); return; end
        if (MAXCHK && len > MAXR[c]) return;
        if (nr[c] < v) return;
        for (int k = 1; k < v; k++) begin
            if (hs[c][k] != v - k) return;
            if (v - k == 1) begin
                if (ones_len(hl[c][k], MAXR[c]) < MINR[c]) return;
            end else begin
                if (hl[c][k] < MINR[c]) return;
                if (MAXCHK && hl[c][k] > MAXR[c]) return;
            end
        end
        st = v; r = len;
    endfunction

    task automatic model_tick();
        int st, r;
        bit a;
        for (int c = 0; c < 3; c++) begin
            model_eval(c, st, r);
            a = (st == NS) && (r >= MINR[c]);
            if (a && !mans[c] && mcnt[c] < CMAX[c]) mcnt[c]++;
            mans[c] = a; mst[c] = st;
        end
    endtask

    function automatic int dut_ans(input int c);
        case (c) 0: return int'(ans0); 1: return int'(ans1); default: return int'(ans2); endcase
    endfunction
    function automatic int dut_st(input int c);
        case (c) 0: return int'(st0); 1: return int'(st1); default: return int'(st2); endcase
    endfunction
    function automatic int dut_cnt(input int c);
        case (c) 0: return int'(mc0); 1: return int'(mc1); default: return int'(mc2); endcase
    endfunction

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("u%0d ans", c), dut_ans(c), int'(mans[c]));
            chk($sformatf("u%0d stage", c), dut_st(c), mst[c]);
            chk($sformatf("u%0d match_cnt", c), dut_cnt(c), mcnt[c]);
        end
    endtask

    task automatic step(input bit v, input int s, input bit c_clr);
        clr = c_clr; in_valid = v; sym = 2'(s);
        @(posedge clk);
        #1;
        if (c_clr) model_clear();
        else if (v) model_push(s);
        model_tick();
        check_all();
        clr = 1'b0; in_valid = 1'b0;
    endtask

    typedef struct { int sym; bit ans; } vec_t;
    vec_t tbl [17];

    initial begin
        int sq [17] = '{1,1,2,3,3,1,2,1,1,1,2,2,2,3,3,3,1};
        bit ea [17] = '{0,0,0,1,1,0,0,0,0,0,0,0,0,1,1,1,0};
        int a1 [5] = '{1,2,2,3,3};
        int a2 [6] = '{1,1,2,2,3,3};
        int a3 [4] = '{1,2,3,3};
        int b2 [6] = '{0,0,0,0,0,1};
        int b3 [4] = '{0,0,1,1};
        int prev, rr, s;
        for (int i = 0; i < 17; i++) begin tbl[i].sym = sq[i]; tbl[i].ans = ea[i]; end

        model_clear();
        #3;
        check_all();
        #9 rst_n = 1'b1;

        // Main vector table, then the same with an idle gap between the two 3s
        for (int i = 0; i < 17; i++) begin
            step(1'b1, tbl[i].sym, 1'b0);
            chk("tbl ans", int'(ans0), int'(tbl[i].ans));
        end
        chk("tbl final match_cnt", int'(mc0), 2);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, tbl[i].sym, 1'b0);
            chk("gap ans", int'(ans0), int'(tbl[i].ans));
            if (i == 3) begin
                for (int g = 0; g < 5; g++) begin
                    step(1'b0, $urandom_range(0, 3), 1'b0);
                    chk("gap stage hold", int'(st0), 3);
                    chk("gap ans hold", int'(ans0), 1);
                end
            end
        end
        chk("gap final match_cnt", int'(mc0), 2);

        // Ordering errors
        step(1'b0, 0, 1'b1);
        step(1'b1, 1, 1'b0); step(1'b1, 3, 1'b0);
        chk("order 1 3 stage", int'(st0), 0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 2, 1'b0); step(1'b1, 3, 1'b0);
        chk("order 2 3 ans", int'(ans0), 0);
        step(1'b0, 0, 1'b1);
        step(1'b1, 1, 1'b0); step(1'b1, 2, 1'b0); step(1'b1, 0, 1'b0);
        chk("order 1 2 0 stage", int'(st0), 0);
        step(1'b1, 3, 1'b0);
        chk("order 1 2 0 3 ans", int'(ans0), 0);

        // MIN_RUN=2 instance
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, a1[i], 1'b0);
            chk("minrun early ans", int'(ans1), 0);
        end
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, a2[i], 1'b0);
            chk("minrun full ans", int'(ans1), b2[i]);
        end

        // MAX_RUN=2 instance: a third 3 overruns only when the check is built in
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, a3[i], 1'b0);
            chk("maxrun ans", int'(ans2), b3[i]);
        end
        step(1'b1, 3, 1'b0);
        chk("maxrun overrun ans", int'(ans2), MAXCHK ? 0 : 1);
        chk("maxrun overrun stage", int'(st2), MAXCHK ? 0 : 3);

        // CNT_W=2 saturation after four patterns
        step(1'b0, 0, 1'b1);
        for (int p = 0; p < 4; p++)
            for (int k = 1; k <= 3; k++) step(1'b1, k, 1'b0);
        chk("cnt saturate", int'(mc2), 3);

        // Async reset mid-pattern, then restart only from a later 1
        step(1'b0, 0, 1'b1);
        step(1'b1, 1, 1'b0); step(1'b1, 2, 1'b0); step(1'b1, 3, 1'b0);
        chk("pre-reset ans", int'(ans0), 1);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        chk("async ans", int'(ans0), 0);
        chk("async stage", int'(st0), 0);
        chk("async match_cnt", int'(mc0), 0);
        #2 rst_n = 1'b1;
        step(1'b1, 2, 1'b0); step(1'b1, 3, 1'b0);
        chk("post-reset 2 3 stage", int'(st0), 0);
        step(1'b1, 1, 1'b0);
        chk("post-reset 1 stage", int'(st0), 1);

        // clr wins over a valid symbol
        step(1'b1, 2, 1'b0);
        step(1'b1, 1, 1'b1);
        chk("clr stage", int'(st0), 0);

        // Biased random stream against the model
        prev = 0;
        for (int n = 0; n < 1500; n++) begin
            rr = $urandom_range(0, 9);
            if (rr < 4) s = prev;
            else if (rr < 7) s = (prev + 1) % 4;
            else if (rr == 7) s = 1;
            else s = $urandom_range(0, 3);
            step($urandom_range(0, 6) != 0, s, $urandom_range(0, 59) == 0);
            if (in_valid == 1'b0) prev = s;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
